uart_bus_bridge: RTL and testbench
==================================

// Module: uart_bus_bridge
// PURPOSE
//  Serial-to-bus initiator: receives 8N1 command frames on rx_in, issues single read/write cycles
//  on the peripheral bus as master, returns ack/read data on tx_out. Host-side debug/load path;
//  drives the same address/sel/read/write_mask/write_value bus the uart peripheral responds on.
// PARAMETERS
//  CLK_DIV      434   clocks per bit minus 1 (bit period = CLK_DIV+1 clocks); must be >= 3
//  TIMEOUT_CLKS 2^20  inter-byte idle clocks before parser abort (only with UART_BRIDGE_TIMEOUT_EN)
// PORTS
//  clk              in   1   single clock, all logic on posedge
//  reset            in   1   synchronous, active-high
//  rx_in            in   1   serial in, idle high (pre-synchronised externally)
//  tx_out           out  1   serial out, idle high
//  address_out      out  64  bus address, {32'b0, addr32}
//  sel_out          out  1   bus select, one-cycle pulse per transaction
//  read_out         out  1   high with sel_out on reads
//  write_mask_out   out  4   4'b1111 with sel_out on writes, else 0
//  write_value_out  out  64  {32'b0, data32}
//  read_value_in    in   64  combinational read data, valid in the sel_out cycle; [31:0] used
//  busy_out         out  1   high whenever parser state != IDLE or transmitter active
// BEHAVIOUR
//  Reset: tx_out=1, sel_out=0, read_out=0, write_mask_out=0, busy_out=0, address/write_value=0,
//   rx/tx bit counters cleared, parser IDLE. Reset mid-frame aborts everything within 1 cycle.
//  RX: falling edge on rx_in while idle starts frame; start bit re-sampled at CLK_DIV/2; if high,
//   false start, ignored. 8 data bits LSB first sampled mid-bit; stop bit sampled: 1 -> byte valid
//   (1-cycle strobe), 0 -> framing error, byte discarded, parser forced to IDLE.
//  Protocol: cmd byte 0x57 'W' -> 4 addr bytes -> 4 data bytes; 0x52 'R' -> 4 addr bytes.
//   Multi-byte fields little-endian. Any other cmd byte in IDLE -> reply 0x3F '?', stay IDLE.
//  Parser states: IDLE -> ADDR(cnt 0..3) -> DATA(cnt 0..3, writes only) -> BUS -> RESP -> IDLE.
//  BUS: exactly one cycle, entered the cycle after the final byte strobe; sel_out=1 with
//   read_out or write_mask_out; read_value_in[31:0] captured in that same cycle.
//  RESP: write -> one byte 0x4B 'K'; read -> 4 data bytes LSB-byte first. First start bit driven
//   the cycle after BUS; back-to-back bytes, no idle gap beyond one stop bit.
//  TX frame: start(0), 8 data LSB first, stop(1); each bit held CLK_DIV+1 clocks.
//  Bytes received during RESP are discarded (host must wait for full response).
//  Address/data registers update only on byte strobes; outputs hold last values outside BUS.
//  Counters: bit-clock counters 16 bit, byte counters 2 bit; no wrap beyond 3 (state advances).
// CONFIGURATION
//  UART_BRIDGE_TIMEOUT_EN defined: counter reloaded each byte strobe; if parser in ADDR/DATA and
//   TIMEOUT_CLKS clocks elapse without a strobe, parser returns to IDLE silently, no bus cycle.
//  Not defined: no timeout logic; partial commands wait indefinitely (only reset/framing error clear).
// STRUCTURE
//  Shared package uart_bridge_pkg: command codes 'R','W', reply codes 'K','?', parser state enum,
//   bit-frame width constant (10).
//  Sub-module uart_byte_io: 8N1 serialiser/deserialiser (byte strobe + framing error out,
//   byte load/ready in); uart_bus_bridge holds parser FSM and bus interface.
// TESTING (CLK_DIV=15 for sim)
//  Write: send 57 10 00 00 00 EF BE AD DE -> one sel_out cycle, address_out=0x10,
//   write_value_out=0xDEADBEEF, write_mask_out=4'b1111; tx returns 0x4B.
//  Read: bus model returns 0x12345678 at 0x04; send 52 04 00 00 00 -> sel_out+read_out once;
//   tx returns 78 56 34 12.
//  Unknown cmd 0x41 -> tx 0x3F, no sel_out; following valid 'R' completes normally.
//  Framing error: 'W' byte with stop bit 0 after 2 addr bytes -> IDLE, no sel_out; next 'W' ok.
//  False start: 4-clock low glitch on rx_in -> no byte strobe, busy_out stays 0.
//  Reset asserted mid read response -> tx_out=1 next cycle, busy_out=0; with
//   UART_BRIDGE_TIMEOUT_EN, 'R' + 2 bytes then silence > TIMEOUT_CLKS -> IDLE, no sel_out.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_bridge_pkg                                              |
// | Description : Shared command/reply codes, frame width and state encodings  |
// |               for the UART-to-bus bridge.                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package uart_bridge_pkg;

    // Host command bytes
    localparam logic [7:0] c_CMD_WRITE  = 8'h57;   // 'W'
    localparam logic [7:0] c_CMD_READ   = 8'h52;   // 'R'

    // Reply bytes
    localparam logic [7:0] c_RSP_OK     = 8'h4B;   // 'K'
    localparam logic [7:0] c_RSP_ERR    = 8'h3F;   // '?'

    // start + 8 data + stop
    localparam int         c_FRAME_BITS = 10;

    // Command parser states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } parser_state_t;

    // Serial receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_bus_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_bus_bridge_if                                           |
// | Description : Single-cycle peripheral bus driven by the bridge (master)    |
// |               and answered by a peripheral (slave).                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface uart_bus_bridge_if;
    logic [63:0] address_out;
    logic        sel_out;
    logic        read_out;
    logic [3:0]  write_mask_out;
    logic [63:0] write_value_out;
    logic [63:0] read_value_in;

    modport master (
        output address_out, sel_out, read_out, write_mask_out, write_value_out,
        input  read_value_in
    );

    modport slave (
        input  address_out, sel_out, read_out, write_mask_out, write_value_out,
        output read_value_in
    );
endinterface
`default_nettype wire

// File: rtl/uart_byte_io.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_byte_io                                                 |
// | Description : 8N1 deserialiser (byte strobe / framing error) and 8N1       |
// |               serialiser (load / ready) sharing one bit period.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_byte_io
    import uart_bridge_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic       o_rx_strobe,
    output logic [7:0] o_rx_data,
    output logic       o_rx_frame_err,
    input  logic       i_tx_load,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_active,
    output logic       o_tx
);

    localparam logic [15:0] c_BIT_LAST    = 16'(CLK_DIV);
    localparam logic [15:0] c_HALF        = 16'(CLK_DIV / 2);
    localparam logic [3:0]  c_TX_LAST_BIT = 4'(c_FRAME_BITS - 1);

    rx_state_t   r_rx_state_q, w_rx_state_d;
    logic [15:0] r_rx_cnt_q,   w_rx_cnt_d;
    logic [2:0]  r_rx_bit_q,   w_rx_bit_d;
    logic [7:0]  r_rx_shift_q, w_rx_shift_d;
    logic        r_rx_strb_q,  w_rx_strb_d;
    logic        r_rx_ferr_q,  w_rx_ferr_d;
    logic        r_rx_prev_q;

    logic        r_tx_active_q, w_tx_active_d;
    logic [9:0]  r_tx_shift_q,  w_tx_shift_d;
    logic [15:0] r_tx_cnt_q,    w_tx_cnt_d;
    logic [3:0]  r_tx_bit_q,    w_tx_bit_d;
    logic        w_tx_last;

    // Receiver: edge-detect start, confirm at half bit, then sample each bit mid-period
    always_comb begin
        w_rx_state_d = r_rx_state_q;
        w_rx_cnt_d   = r_rx_cnt_q;
        w_rx_bit_d   = r_rx_bit_q;
        w_rx_shift_d = r_rx_shift_q;
        w_rx_strb_d  = 1'b0;
        w_rx_ferr_d  = 1'b0;
        case (r_rx_state_q)
            RX_IDLE: begin
                if (r_rx_prev_q && !i_rx) begin
                    w_rx_state_d = RX_START;
                    w_rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (r_rx_cnt_q == c_HALF) begin
                    w_rx_cnt_d   = '0;
                    w_rx_bit_d   = '0;
                    // Line back high at mid start bit: glitch, not a frame
                    w_rx_state_d = i_rx ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_d = r_rx_cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt_q == c_BIT_LAST) begin
                    w_rx_cnt_d   = '0;
                    w_rx_shift_d = {i_rx, r_rx_shift_q[7:1]};
                    if (r_rx_bit_q == 3'd7) begin
                        w_rx_state_d = RX_STOP;
                    end else begin
                        w_rx_bit_d = r_rx_bit_q + 3'd1;
                    end
                end else begin
                    w_rx_cnt_d = r_rx_cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt_q == c_BIT_LAST) begin
                    w_rx_strb_d  = i_rx;
                    w_rx_ferr_d  = !i_rx;
                    w_rx_state_d = RX_IDLE;
                end else begin
                    w_rx_cnt_d = r_rx_cnt_q + 16'd1;
                end
            end
            default: w_rx_state_d = RX_IDLE;
        endcase
    end

    // Transmitter accepts the next byte on the final stop-bit clock so bytes run back-to-back
    assign w_tx_last  = r_tx_active_q && (r_tx_bit_q == c_TX_LAST_BIT) && (r_tx_cnt_q == c_BIT_LAST);
    assign o_tx_ready = !r_tx_active_q || w_tx_last;

    // Transmitter: shift out {stop, data, start} one bit period at a time
    always_comb begin
        w_tx_active_d = r_tx_active_q;
        w_tx_shift_d  = r_tx_shift_q;
        w_tx_cnt_d    = r_tx_cnt_q;
        w_tx_bit_d    = r_tx_bit_q;
        if (i_tx_load && o_tx_ready) begin
            w_tx_active_d = 1'b1;
            w_tx_shift_d  = {1'b1, i_tx_byte, 1'b0};
            w_tx_cnt_d    = '0;
            w_tx_bit_d    = '0;
        end else if (r_tx_active_q) begin
            if (r_tx_cnt_q == c_BIT_LAST) begin
                w_tx_cnt_d = '0;
                if (r_tx_bit_q == c_TX_LAST_BIT) begin
                    w_tx_active_d = 1'b0;
                end else begin
                    w_tx_shift_d = {1'b1, r_tx_shift_q[9:1]};
                    w_tx_bit_d   = r_tx_bit_q + 4'd1;
                end
            end else begin
                w_tx_cnt_d = r_tx_cnt_q + 16'd1;
            end
        end
    end

    // State registers for both directions
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state_q  <= RX_IDLE;
            r_rx_cnt_q    <= '0;
            r_rx_bit_q    <= '0;
            r_rx_shift_q  <= '0;
            r_rx_strb_q   <= 1'b0;
            r_rx_ferr_q   <= 1'b0;
            r_rx_prev_q   <= 1'b1;
            r_tx_active_q <= 1'b0;
            r_tx_shift_q  <= '1;
            r_tx_cnt_q    <= '0;
            r_tx_bit_q    <= '0;
        end else begin
            r_rx_state_q  <= w_rx_state_d;
            r_rx_cnt_q    <= w_rx_cnt_d;
            r_rx_bit_q    <= w_rx_bit_d;
            r_rx_shift_q  <= w_rx_shift_d;
            r_rx_strb_q   <= w_rx_strb_d;
            r_rx_ferr_q   <= w_rx_ferr_d;
            r_rx_prev_q   <= i_rx;
            r_tx_active_q <= w_tx_active_d;
            r_tx_shift_q  <= w_tx_shift_d;
            r_tx_cnt_q    <= w_tx_cnt_d;
            r_tx_bit_q    <= w_tx_bit_d;
        end
    end

    assign o_rx_strobe    = r_rx_strb_q;
    assign o_rx_frame_err = r_rx_ferr_q;
    assign o_rx_data      = r_rx_shift_q;
    assign o_tx_active    = r_tx_active_q;
    assign o_tx           = r_tx_active_q ? r_tx_shift_q[0] : 1'b1;

endmodule
`default_nettype wire

// File: rtl/uart_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_bus_bridge                                              |
// | Description : Serial command parser issuing single read/write cycles on    |
// |               the peripheral bus and returning ack / read data serially.   |
// |               Optional inter-byte timeout: UART_BRIDGE_TIMEOUT_EN.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int CLK_DIV      = 434,
    parameter int TIMEOUT_CLKS = 1 << 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_in,
    output logic              tx_out,
    output logic              busy_out,
    uart_bus_bridge_if.master bus
);

    // Reject configurations the bit-timing logic cannot honour
    if (CLK_DIV < 3 || TIMEOUT_CLKS < 2) begin : g_bad_params
        $error("uart_bus_bridge: CLK_DIV must be >= 3 and TIMEOUT_CLKS >= 2");
    end

    logic       w_rx_strobe;
    logic [7:0] w_rx_data;
    logic       w_rx_ferr;
    logic       w_tx_load;
    logic [7:0] w_tx_byte;
    logic       w_tx_ready;
    logic       w_tx_active;

    uart_byte_io #(
        .CLK_DIV (CLK_DIV)
    ) u_byte_io (
        .clk            (clk),
        .reset          (reset),
        .i_rx           (rx_in),
        .o_rx_strobe    (w_rx_strobe),
        .o_rx_data      (w_rx_data),
        .o_rx_frame_err (w_rx_ferr),
        .i_tx_load      (w_tx_load),
        .i_tx_byte      (w_tx_byte),
        .o_tx_ready     (w_tx_ready),
        .o_tx_active    (w_tx_active),
        .o_tx           (tx_out)
    );

    parser_state_t r_state_q,    w_state_d;
    logic          r_is_write_q, w_is_write_d;
    logic [1:0]    r_cnt_q,      w_cnt_d;
    logic [31:0]   r_addr_q,     w_addr_d;     // assembled little-endian
    logic [31:0]   r_data_q,     w_data_d;
    logic [31:0]   r_resp_q,     w_resp_d;     // read data, shifted out a byte at a time
    logic [31:0]   r_addr_out_q, w_addr_out_d; // bus-visible copies, updated only on completion
    logic [31:0]   r_wval_out_q, w_wval_out_d;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int               c_TO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CLKS - 1);
    logic [c_TO_W-1:0] r_idle_q, w_idle_d;
`endif

    // Parser: collect command bytes, run one bus cycle, stream the reply
    always_comb begin
        w_state_d    = r_state_q;
        w_is_write_d = r_is_write_q;
        w_cnt_d      = r_cnt_q;
        w_addr_d     = r_addr_q;
        w_data_d     = r_data_q;
        w_resp_d     = r_resp_q;
        w_addr_out_d = r_addr_out_q;
        w_wval_out_d = r_wval_out_q;
        w_tx_load    = 1'b0;
        w_tx_byte    = c_RSP_ERR;
        case (r_state_q)
            ST_IDLE: begin
                if (w_rx_strobe) begin
                    w_cnt_d = '0;
                    if (w_rx_data == c_CMD_WRITE) begin
                        w_state_d    = ST_ADDR;
                        w_is_write_d = 1'b1;
                    end else if (w_rx_data == c_CMD_READ) begin
                        w_state_d    = ST_ADDR;
                        w_is_write_d = 1'b0;
                    end else begin
                        w_tx_load = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (w_rx_ferr) begin
                    w_state_d = ST_IDLE;
                end else if (w_rx_strobe) begin
                    w_addr_d = {w_rx_data, r_addr_q[31:8]};
                    if (r_cnt_q == 2'd3) begin
                        w_cnt_d = '0;
                        if (r_is_write_q) begin
                            w_state_d = ST_DATA;
                        end else begin
                            w_state_d    = ST_BUS;
                            w_addr_out_d = w_addr_d;
                        end
                    end else begin
                        w_cnt_d = r_cnt_q + 2'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_rx_ferr) begin
                    w_state_d = ST_IDLE;
                end else if (w_rx_strobe) begin
                    w_data_d = {w_rx_data, r_data_q[31:8]};
                    if (r_cnt_q == 2'd3) begin
                        w_cnt_d      = '0;
                        w_state_d    = ST_BUS;
                        w_addr_out_d = r_addr_q;
                        w_wval_out_d = w_data_d;
                    end else begin
                        w_cnt_d = r_cnt_q + 2'd1;
                    end
                end
            end
            ST_BUS: begin
                // First reply byte is loaded here so its start bit appears next cycle
                w_tx_load = 1'b1;
                w_tx_byte = r_is_write_q ? c_RSP_OK : bus.read_value_in[7:0];
                w_resp_d  = {8'h00, bus.read_value_in[31:8]};
                w_cnt_d   = 2'd1;
                w_state_d = ST_RESP;
            end
            ST_RESP: begin
                // Incoming bytes and framing errors are ignored until the reply is queued
                if (r_is_write_q) begin
                    w_state_d = ST_IDLE;
                end else if (w_tx_ready) begin
                    w_tx_load = 1'b1;
                    w_tx_byte = r_resp_q[7:0];
                    w_resp_d  = {8'h00, r_resp_q[31:8]};
                    if (r_cnt_q == 2'd3) begin
                        w_cnt_d   = '0;
                        w_state_d = ST_IDLE;
                    end else begin
                        w_cnt_d = r_cnt_q + 2'd1;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

`ifdef UART_BRIDGE_TIMEOUT_EN
        // Abandon a partial command after TIMEOUT_CLKS clocks without a byte
        w_idle_d = '0;
        if ((r_state_q == ST_ADDR || r_state_q == ST_DATA) && !w_rx_strobe && !w_rx_ferr) begin
            w_idle_d = r_idle_q + 1'b1;
            if (r_idle_q == c_TO_LAST) begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
                w_idle_d  = '0;
            end
        end
`endif
    end

    // Parser registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= ST_IDLE;
            r_is_write_q <= 1'b0;
            r_cnt_q      <= '0;
            r_addr_q     <= '0;
            r_data_q     <= '0;
            r_resp_q     <= '0;
            r_addr_out_q <= '0;
            r_wval_out_q <= '0;
`ifdef UART_BRIDGE_TIMEOUT_EN
            r_idle_q     <= '0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_is_write_q <= w_is_write_d;
            r_cnt_q      <= w_cnt_d;
            r_addr_q     <= w_addr_d;
            r_data_q     <= w_data_d;
            r_resp_q     <= w_resp_d;
            r_addr_out_q <= w_addr_out_d;
            r_wval_out_q <= w_wval_out_d;
`ifdef UART_BRIDGE_TIMEOUT_EN
            r_idle_q     <= w_idle_d;
`endif
        end
    end

    assign bus.sel_out         = (r_state_q == ST_BUS);
    assign bus.read_out        = (r_state_q == ST_BUS) && !r_is_write_q;
    assign bus.write_mask_out  = ((r_state_q == ST_BUS) && r_is_write_q) ? 4'b1111 : 4'b0000;
    assign bus.address_out     = {32'h0, r_addr_out_q};
    assign bus.write_value_out = {32'h0, r_wval_out_q};
    assign busy_out            = (r_state_q != ST_IDLE) || w_tx_active;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_bus_bridge                                           |
// | Description : Scoreboard bench: commands are predicted from the protocol   |
// |               rules, monitors decode the bus and serial reply and compare. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_bus_bridge;

    localparam int c_DIV  = 15;
    localparam int c_BIT  = c_DIV + 1;
    localparam int c_TOUT = 2000;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } bus_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_in = 1'b1;
    logic tx_out;
    logic busy_out;

    int checks = 0;
    int errors = 0;

    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] cmd[$];

    uart_bus_bridge_if bus_if ();

    uart_bus_bridge #(
        .CLK_DIV      (c_DIV),
        .TIMEOUT_CLKS (c_TOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_in    (rx_in),
        .tx_out   (tx_out),
        .busy_out (busy_out),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // Peripheral model: fixed contents, upper half junk the bridge must ignore
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h4) return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus_if.read_value_in = {~bus_if.address_out[31:0], mem_model(bus_if.address_out[31:0])};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Predict bus cycle and reply bytes for the command in cmd[]
    task automatic predict();
        logic [31:0] a, d, r;
        if (cmd.size() == 9 && cmd[0] == 8'h57) begin
            a = {cmd[4], cmd[3], cmd[2], cmd[1]};
            d = {cmd[8], cmd[7], cmd[6], cmd[5]};
            exp_bus.push_back('{a, 1'b1, d});
            exp_tx.push_back(8'h4B);
        end else if (cmd.size() == 5 && cmd[0] == 8'h52) begin
            a = {cmd[4], cmd[3], cmd[2], cmd[1]};
            r = mem_model(a);
            exp_bus.push_back('{a, 1'b0, 32'h0});
            for (int i = 0; i < 4; i++) exp_tx.push_back(r[8*i +: 8]);
        end else if (cmd.size() == 1) begin
            exp_tx.push_back(8'h3F);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_in = 1'b0;
        repeat (c_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (c_BIT) @(negedge clk);
        end
        rx_in = stop;
        repeat (c_BIT) @(negedge clk);
        rx_in = 1'b1;
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(cmd[i], 1'b1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (n < 6000 && !(exp_tx.size() == 0 && exp_bus.size() == 0 && !busy_out)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 6000) begin
            errors++;
            $display("FAIL %s_done actual=pending(tx=%0d bus=%0d busy=%0b) required=idle",
                     name, exp_tx.size(), exp_bus.size(), busy_out);
        end
    endtask

    task automatic mk_write(input logic [31:0] a, input logic [31:0] d);
        cmd = '{8'h57, a[7:0], a[15:8], a[23:16], a[31:24], d[7:0], d[15:8], d[23:16], d[31:24]};
    endtask

    task automatic mk_read(input logic [31:0] a);
        cmd = '{8'h52, a[7:0], a[15:8], a[23:16], a[31:24]};
    endtask

    task automatic run_cmd(input string name);
        predict();
        send_range(0, cmd.size() - 1);
        wait_done(name);
    endtask

    // Monitor: bus cycles and serial reply decoding, both sampled on negedge
    int         tm_state = 0;
    int         tm_cnt   = 0;
    logic [7:0] tm_shift = 8'h00;

    initial begin
        bus_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                tm_state = 0;
            end else begin
                if (bus_if.sel_out) begin
                    if (exp_bus.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_sel actual=addr %h required=no bus cycle",
                                 bus_if.address_out);
                    end else begin
                        e = exp_bus.pop_front();
                        chk("bus_addr", bus_if.address_out, {32'h0, e.addr});
                        chk("bus_read", 64'(bus_if.read_out), 64'(!e.wr));
                        chk("bus_mask", 64'(bus_if.write_mask_out), e.wr ? 64'hF : 64'h0);
                        if (e.wr) chk("bus_wdata", bus_if.write_value_out, {32'h0, e.data});
                    end
                end
                if (tm_state == 0) begin
                    if (tx_out == 1'b0) begin
                        tm_state = 1;
                        tm_cnt   = 0;
                    end
                end else begin
                    tm_cnt++;
                    if (tm_cnt == c_BIT / 2) begin
                        if (tx_out !== 1'b0) begin
                            chk("tx_start", 64'(tx_out), 64'h0);
                            tm_state = 0;
                        end
                    end else if (tm_cnt > c_BIT / 2 && tm_cnt < c_BIT / 2 + 9 * c_BIT &&
                                 ((tm_cnt - c_BIT / 2) % c_BIT) == 0) begin
                        tm_shift = {tx_out, tm_shift[7:1]};
                    end else if (tm_cnt == c_BIT / 2 + 9 * c_BIT) begin
                        chk("tx_stop", 64'(tx_out), 64'h1);
                        if (exp_tx.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_tx actual=%h required=no byte", tm_shift);
                        end else begin
                            chk("tx_byte", 64'(tm_shift), 64'(exp_tx.pop_front()));
                        end
                        tm_state = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [31:0] a, d;
        int          k, n;
        logic        stuck;

        repeat (4) @(negedge clk);
        chk("rst_tx", 64'(tx_out), 64'h1);
        chk("rst_busy", 64'(busy_out), 64'h0);
        chk("rst_sel", 64'(bus_if.sel_out), 64'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_read", 64'(bus_if.read_out), 64'h0);
        chk("rst_mask", 64'(bus_if.write_mask_out), 64'h0);
        chk("rst_addr", bus_if.address_out, 64'h0);
        chk("rst_wval", bus_if.write_value_out, 64'h0);
        chk("rst_tx_idle", 64'(tx_out), 64'h1);

        // Directed write and read
        mk_write(32'h10, 32'hDEAD_BEEF);
        run_cmd("write_dir");
        mk_read(32'h4);
        run_cmd("read_dir");

        // Unknown command then a normal read
        cmd = '{8'h41};
        run_cmd("unknown");
        mk_read(32'h0000_0100);
        run_cmd("read_after_unknown");

        // Framing error two address bytes into a write
        cmd = '{8'h57, 8'h22, 8'h33};
        send_range(0, 2);
        send_byte(8'hA7, 1'b0);
        repeat (40) @(negedge clk);
        chk("ferr_idle", 64'(busy_out), 64'h0);
        mk_write(32'hCAFE_0008, 32'h0BAD_F00D);
        run_cmd("write_after_ferr");

        // False start glitch
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        stuck = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy_out) stuck = 1'b1;
        end
        chk("false_start_busy", 64'(stuck), 64'h0);

        // Randomised mix including address extremes
        for (int i = 0; i < 14; i++) begin
            k = $urandom_range(0, 9);
            a = $urandom();
            d = $urandom();
            if (i == 0) a = 32'h0;
            if (i == 1) a = 32'hFFFF_FFFF;
            if (k < 4) begin
                mk_write(a, d);
            end else if (k < 8) begin
                mk_read(a);
            end else begin
                d[7:0] = $urandom_range(0, 255);
                if (d[7:0] == 8'h57 || d[7:0] == 8'h52) d[7:0] = 8'h00;
                cmd = '{d[7:0]};
            end
            run_cmd("random");
        end

        // Partial command followed by long silence
        mk_read($urandom());
`ifdef UART_BRIDGE_TIMEOUT_EN
        send_range(0, 2);
        repeat (c_TOUT + 500) @(negedge clk);
        chk("timeout_idle", 64'(busy_out), 64'h0);
        mk_read(32'h4);
        run_cmd("read_after_timeout");
`else
        predict();
        send_range(0, 2);
        repeat (c_TOUT + 500) @(negedge clk);
        chk("partial_waits", 64'(busy_out), 64'h1);
        send_range(3, 4);
        wait_done("partial_resume");
`endif

        // Reset in the middle of a read response
        mk_read(32'h4);
        predict();
        send_range(0, 4);
        n = 0;
        while (n < 3000 && exp_tx.size() > 2) begin
            @(negedge clk);
            n++;
        end
        chk("resp_progress", 64'(n < 3000), 64'h1);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_tx.delete();
        chk("midrst_tx", 64'(tx_out), 64'h1);
        chk("midrst_busy", 64'(busy_out), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        mk_read(32'h4);
        run_cmd("read_after_reset");

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
